axi_read_arbiter: RTL and testbench

//  Shares one AXI4 read port of the memory controller (mem) among NUM_MASTERS read

---
 rtl/axi_arb_pkg.sv | 24 ++
 rtl/rr_pick.sv | 31 +++
 rtl/axi_read_arbiter.sv | 126 ++++++++++++
 tb/tb_axi_read_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the AXI read arbiter.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_ADDR   = 2'd2,
        S_DATA   = 2'd3
    } e_arb_state;

    // Upper bound on requesters; callers size-cast the one-hot result down.
    localparam int MAX_MASTERS = 32;

    // One-hot vector with bit idx set, provided idx addresses one of n requesters.
    function automatic logic [MAX_MASTERS-1:0] onehot(input int idx, input int n);
        logic [MAX_MASTERS-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_MASTERS; i++) begin
            v[i] = (i == idx) && (i < n);
        end
        return v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request strictly after ptr, wrapping.
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W:0] sum;

    // Scan ptr+1, ptr+2 ... ptr+N (mod N); the first hit wins.
    always_comb begin
        any = 1'b0;
        idx = '0;
        sum = '0;
        for (int k = 1; k <= N; k++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(N)) begin
                sum = sum - (IDX_W+1)'(N);
            end
            if (!any && req[sum[IDX_W-1:0]]) begin
                any = 1'b1;
                idx = sum[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI4 read port among NUM_MASTERS requesters.
// One read outstanding at a time; R channel is passed through combinationally.
module axi_read_arbiter
    import axi_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    localparam int IDX_W      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                              axi_clk,
    input  logic                              axi_reset,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] up_araddr,
    input  logic [NUM_MASTERS-1:0]            up_arvalid,
    output logic [NUM_MASTERS-1:0]            up_arready,
    output logic [DATA_WIDTH-1:0]             up_rdata,
    output logic                              up_rlast,
    output logic [NUM_MASTERS-1:0]            up_rvalid,
    input  logic [NUM_MASTERS-1:0]            up_rready,
    output logic [ADDR_WIDTH-1:0]             axi_araddr,
    output logic                              axi_arvalid,
    input  logic                              axi_arready,
    input  logic [DATA_WIDTH-1:0]             axi_rdata,
    input  logic                              axi_rlast,
    input  logic                              axi_rvalid,
    output logic                              axi_rready,
    output logic [IDX_W-1:0]                  grant_idx
);

    e_arb_state             state_q;
    logic [NUM_MASTERS-1:0] arready_q;
    logic                   arvalid_q;
    logic [ADDR_WIDTH-1:0]  araddr_q;
    logic [IDX_W-1:0]       grant_q;
    logic [IDX_W-1:0]       rr_ptr_q;

    logic                   pick_any;
    logic [IDX_W-1:0]       pick_idx;
    logic [NUM_MASTERS-1:0] grant_oh;
    logic [ADDR_WIDTH-1:0]  addr_arr [NUM_MASTERS];

    // Unpack the flat address bus so the granted address can be selected by index.
    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_addr
            assign addr_arr[gi] = up_araddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        end
    endgenerate

    rr_pick #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req (up_arvalid),
        .ptr (rr_ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign grant_oh = NUM_MASTERS'(onehot(int'(grant_q), NUM_MASTERS));

    // Arbitration / address FSM; all handshake outputs are registered here.
    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            state_q   <= S_IDLE;
            arready_q <= '0;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            grant_q   <= '0;
            rr_ptr_q  <= IDX_W'(NUM_MASTERS - 1);
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_any) begin
                        grant_q   <= pick_idx;
                        arready_q <= NUM_MASTERS'(onehot(int'(pick_idx), NUM_MASTERS));
                        state_q   <= S_ACCEPT;
                    end else begin
                        arready_q <= '0;
                    end
                end
                S_ACCEPT: begin
                    // A requester withdrawing arvalid is dropped without moving rr_ptr.
                    arready_q <= '0;
                    if (up_arvalid[grant_q] && arready_q[grant_q]) begin
                        araddr_q  <= addr_arr[grant_q];
                        arvalid_q <= 1'b1;
                        state_q   <= S_ADDR;
                    end else begin
                        state_q   <= S_IDLE;
                    end
                end
                S_ADDR: begin
                    if (arvalid_q && axi_arready) begin
                        arvalid_q <= 1'b0;
                        state_q   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (axi_rvalid && axi_rready && axi_rlast) begin
                        rr_ptr_q <= grant_q;
                        state_q  <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // R channel routed to the granted requester only while a read is in flight.
    always_comb begin
        up_rvalid  = '0;
        axi_rready = 1'b0;
        if (state_q == S_DATA) begin
            up_rvalid  = axi_rvalid ? grant_oh : '0;
            axi_rready = up_rready[grant_q];
        end
    end

    assign up_arready  = arready_q;
    assign up_rdata    = axi_rdata;
    assign up_rlast    = axi_rlast;
    assign axi_araddr  = araddr_q;
    assign axi_arvalid = arvalid_q;
    assign grant_idx   = grant_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench: arbiter + behavioural single-beat memory + two requesters.
module tb_axi_read_arbiter;

    localparam int NM = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic           axi_clk;
    logic           axi_reset;
    logic [NM*AW-1:0] up_araddr;
    logic [NM-1:0]  up_arvalid;
    logic [NM-1:0]  up_arready;
    logic [DW-1:0]  up_rdata;
    logic           up_rlast;
    logic [NM-1:0]  up_rvalid;
    logic [NM-1:0]  up_rready;
    logic [AW-1:0]  axi_araddr;
    logic           axi_arvalid;
    logic           axi_arready;
    logic [DW-1:0]  axi_rdata;
    logic           axi_rlast;
    logic           axi_rvalid;
    logic           axi_rready;
    logic [0:0]     grant_idx;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [64];
    int          grant_log [$];

    // Values sampled at each rising edge (handshakes seen by the DUT).
    logic          ar_hs_s, r_hs_s;
    logic [AW-1:0] ar_addr_s;
    logic [0:0]    grant_s;
    logic [NM-1:0] up_ar_hs_s, up_r_hs_s, rvalid_vec_s;
    logic [DW-1:0] rdata_s;
    logic          rlast_s;

    axi_read_arbiter #(
        .NUM_MASTERS (NM),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW)
    ) dut (
        .axi_clk     (axi_clk),
        .axi_reset   (axi_reset),
        .up_araddr   (up_araddr),
        .up_arvalid  (up_arvalid),
        .up_arready  (up_arready),
        .up_rdata    (up_rdata),
        .up_rlast    (up_rlast),
        .up_rvalid   (up_rvalid),
        .up_rready   (up_rready),
        .axi_araddr  (axi_araddr),
        .axi_arvalid (axi_arvalid),
        .axi_arready (axi_arready),
        .axi_rdata   (axi_rdata),
        .axi_rlast   (axi_rlast),
        .axi_rvalid  (axi_rvalid),
        .axi_rready  (axi_rready),
        .grant_idx   (grant_idx)
    );

    initial begin
        axi_clk = 1'b0;
        forever #5 axi_clk = ~axi_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] memval(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    always @(posedge axi_clk) begin
        ar_hs_s      <= axi_arvalid & axi_arready;
        ar_addr_s    <= axi_araddr;
        grant_s      <= grant_idx;
        r_hs_s       <= axi_rvalid & axi_rready;
        up_ar_hs_s   <= up_arvalid & up_arready;
        up_r_hs_s    <= up_rvalid & up_rready;
        rdata_s      <= up_rdata;
        rlast_s      <= up_rlast;
        rvalid_vec_s <= up_rvalid;
    end

    // Memory: answers each accepted address with one beat on the next cycle.
    initial begin
        axi_rvalid = 1'b0;
        axi_rlast  = 1'b0;
        axi_rdata  = '0;
        forever begin
            @(negedge axi_clk);
            if (axi_reset) begin
                axi_rvalid = 1'b0;
                axi_rlast  = 1'b0;
            end else begin
                if (r_hs_s === 1'b1) begin
                    axi_rvalid = 1'b0;
                    axi_rlast  = 1'b0;
                end
                if (ar_hs_s === 1'b1) begin
                    axi_rvalid = 1'b1;
                    axi_rlast  = 1'b1;
                    axi_rdata  = mem[ar_addr_s[5:0]];
                    grant_log.push_back(int'(grant_s));
                end
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        errors++;
        $error("FAIL %s observed=timeout expected=handshake", tag);
    endtask

    task automatic req_read(input int m, input logic [31:0] addr, input logic [31:0] exp, input string tag);
        int n;
        @(negedge axi_clk);
        up_araddr[m*AW +: AW] = addr;
        up_arvalid[m] = 1'b1;
        up_rready[m]  = 1'b1;
        n = 0;
        do begin @(negedge axi_clk); n++; end while (up_ar_hs_s[m] !== 1'b1 && n < 300);
        if (n >= 300) timeout({tag, "_ar"});
        up_arvalid[m] = 1'b0;
        n = 0;
        do begin @(negedge axi_clk); n++; end while (up_r_hs_s[m] !== 1'b1 && n < 300);
        if (n >= 300) timeout({tag, "_r"});
        check({tag, "_rdata"}, rdata_s, exp);
        check({tag, "_rvalid"}, rvalid_vec_s, 2'b01 << m);
        check({tag, "_rlast"}, rlast_s, 1'b1);
        $display("read m=%0d addr=%0d data=%08h", m, addr, rdata_s);
    endtask

    task automatic apply_reset(input int cycles);
        @(negedge axi_clk);
        axi_reset = 1'b1;
        repeat (cycles) @(negedge axi_clk);
        axi_reset = 1'b0;
    endtask

    initial begin
        int base;
        int n;
        for (int i = 0; i < 64; i++) mem[i] = memval(i);
        mem[5] = 32'hDEAD_BEEF;
        axi_reset   = 1'b1;
        up_araddr   = '0;
        up_arvalid  = '0;
        up_rready   = '1;
        axi_arready = 1'b1;

        // 1: reset held with random requests -> every output stays quiet
        for (int c = 0; c < 3; c++) begin
            @(negedge axi_clk);
            up_arvalid = 2'($urandom_range(0, 3));
            #1;
            check("t1_reset_outs", {up_arready, up_rvalid, axi_arvalid, axi_rready, grant_idx}, '0);
        end
        @(negedge axi_clk);
        up_arvalid = '0;
        axi_reset  = 1'b0;

        // 2: single read by requester 0
        base = grant_log.size();
        req_read(0, 32'd5, 32'hDEAD_BEEF, "t2");
        check("t2_araddr", ar_addr_s, 32'd5);
        check("t2_grant", grant_log[base], 0);

        // 3: simultaneous requests right after reset -> 0 then 1
        apply_reset(2);
        base = grant_log.size();
        fork
            req_read(0, 32'd3, memval(3), "t3_r0");
            req_read(1, 32'd7, memval(7), "t3_r1");
        join
        check("t3_nlog", grant_log.size(), base + 2);
        check("t3_first", grant_log[base], 0);
        check("t3_second", grant_log[base + 1], 1);

        // 4: both reissue continuously -> strict alternation
        base = grant_log.size();
        fork
            for (int k = 0; k < 8; k++) req_read(0, 32'(16 + 2*k), memval(16 + 2*k), "t4_r0");
            for (int k = 0; k < 8; k++) req_read(1, 32'(17 + 2*k), memval(17 + 2*k), "t4_r1");
        join
        check("t4_nlog", grant_log.size(), base + 16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t4_grant%0d", i), grant_log[base + i], i % 2);
        end

        // 5: requester 1 stalls the R channel; requester 0 must wait
        base = grant_log.size();
        fork
            begin
                int na;
                @(negedge axi_clk);
                up_rready[1] = 1'b0;
                up_araddr[AW +: AW] = 32'd40;
                up_arvalid[1] = 1'b1;
                na = 0;
                do begin @(negedge axi_clk); na++; end while (up_ar_hs_s[1] !== 1'b1 && na < 200);
                if (na >= 200) timeout("t5_r1_ar");
                up_arvalid[1] = 1'b0;
                na = 0;
                do begin @(negedge axi_clk); #1; na++; end while (axi_rvalid !== 1'b1 && na < 200);
                if (na >= 200) timeout("t5_r1_rvalid");
                for (int c = 0; c < 4; c++) begin
                    check("t5_axi_rready", axi_rready, 1'b0);
                    check("t5_rdata_held", up_rdata, memval(40));
                    check("t5_up_rvalid", up_rvalid, 2'b10);
                    check("t5_grant", grant_idx, 1'b1);
                    check("t5_no_arready", up_arready, 2'b00);
                    @(negedge axi_clk); #1;
                end
                up_rready[1] = 1'b1;
                na = 0;
                do begin @(negedge axi_clk); na++; end while (up_r_hs_s[1] !== 1'b1 && na < 200);
                if (na >= 200) timeout("t5_r1_r");
                check("t5_r1_rdata", rdata_s, memval(40));
                $display("read m=1 addr=40 data=%08h (after backpressure)", rdata_s);
            end
            begin
                int nb;
                nb = 0;
                while (grant_log.size() == base && nb < 200) begin @(negedge axi_clk); #2; nb++; end
                req_read(0, 32'd41, memval(41), "t5_r0");
            end
        join
        check("t5_nlog", grant_log.size(), base + 2);
        check("t5_order0", grant_log[base], 1);
        check("t5_order1", grant_log[base + 1], 0);

        // 6: reset while waiting on the downstream address channel
        axi_arready = 1'b0;
        @(negedge axi_clk);
        up_araddr[0 +: AW] = 32'd9;
        up_arvalid[0] = 1'b1;
        n = 0;
        do begin @(negedge axi_clk); #1; n++; end while (axi_arvalid !== 1'b1 && n < 200);
        if (n >= 200) timeout("t6_arvalid");
        check("t6_araddr_before", axi_araddr, 32'd9);
        @(negedge axi_clk);
        axi_reset  = 1'b1;
        up_arvalid = '0;
        @(negedge axi_clk); #1;
        check("t6_after_reset",
              {up_arready, up_rvalid, axi_arvalid, axi_rready, grant_idx, axi_araddr}, '0);
        axi_reset   = 1'b0;
        axi_arready = 1'b1;
        base = grant_log.size();
        req_read(0, 32'd50, memval(50), "t6_fresh");
        check("t6_nlog", grant_log.size(), base + 1);
        check("t6_grant", grant_log[base], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
